wb_stage: RTL and testbench

- Writeback end of the pipeline. Consumes the Memory-stage outputs (RegWriteM, MemtoRegM, RD, ALUOutM, WriteRegM), which are registered in an internal writeback pipeline register.
- Selects the result word, commits it to an internal 32-entry register file, and serves the Decode stage's two combinational read ports with same-cycle write bypass.
- Exports the W-stage destination, write-enable and result to the hazard unit.
- Keeps a committed-write counter for bring-up and debug.

---
 rtl/wb_stage_if.sv | 35 +++
 rtl/wb_stage.sv | 89 ++++++++
 tb/tb_wb_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback-stage bus bundle.
// Groups the M-stage inputs, the Decode read ports and the hazard/debug outputs
// of wb_stage. The slave modport is the writeback stage. The master modport is
// its environment, which drives the M stage and the Decode read addresses.
//   M stage    : RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WriteRegM
//   Decode     : A1, A2 -> RD1, RD2
//   Hazard/dbg : RegWriteW, WriteRegW, ResultW, WriteCount
interface wb_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      RegWriteM;
  logic                      MemtoRegM;
  logic [DATA_WIDTH-1:0]     ReadDataM;
  logic [DATA_WIDTH-1:0]     ALUOutM;
  logic [REG_ADDR_WIDTH-1:0] WriteRegM;
  logic [REG_ADDR_WIDTH-1:0] A1;
  logic [REG_ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0]     RD1;
  logic [DATA_WIDTH-1:0]     RD2;
  logic                      RegWriteW;
  logic [REG_ADDR_WIDTH-1:0] WriteRegW;
  logic [DATA_WIDTH-1:0]     ResultW;
  logic [31:0]               WriteCount;

  modport slave (
    input  RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WriteRegM, A1, A2,
    output RD1, RD2, RegWriteW, WriteRegW, ResultW, WriteCount
  );

  modport master (
    output RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WriteRegM, A1, A2,
    input  RD1, RD2, RegWriteW, WriteRegW, ResultW, WriteCount
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback pipeline stage with an integrated register file.
// The M-stage outputs are registered into the W stage. The result is selected
// from the load data or the ALU output and committed to the register file on
// the edge that ends the W cycle. The Decode read ports see a same-cycle bypass
// of the pending write. A free-running counter tracks the committed writes.
// Ports:
//   CLK : pipeline clock, rising edge
//   RST : asynchronous active-high reset
//   bus : wb_stage_if.slave (M inputs, read ports, hazard/debug outputs)
module wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic       CLK,
  input  logic       RST,
  wb_stage_if.slave  bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic                      reg_write_q, reg_write_d;
  logic                      memto_reg_q, memto_reg_d;
  logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0]     alu_out_q, alu_out_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [31:0]               write_count_q, write_count_d;

  logic [DATA_WIDTH-1:0]     result;
  logic                      commit;

  assign reg_write_d = bus.RegWriteM;
  assign memto_reg_d = bus.MemtoRegM;
  assign read_data_d = bus.ReadDataM;
  assign alu_out_d   = bus.ALUOutM;
  assign write_reg_d = bus.WriteRegM;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      read_data_q <= '0;
      alu_out_q   <= '0;
      write_reg_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      write_reg_q <= write_reg_d;
    end
  end

  assign result = memto_reg_q ? read_data_q : alu_out_q;
  // Writes to register 0 are dropped here, so entry 0 stays at its reset value.
  assign commit = reg_write_q && (write_reg_q != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[write_reg_q] <= result;
    end
  end

  assign write_count_d = commit ? write_count_q + 32'd1 : write_count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) write_count_q <= '0;
    else     write_count_q <= write_count_d;
  end

  // The read ports are pure combinational lookups. An unknown address can only
  // produce an unknown read value. It cannot reach any storage update.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (a == '0)                                v = '0;
    else if (reg_write_q && (a == write_reg_q)) v = result;
    else                                        v = regs_q[a];
    return v;
  endfunction

  assign bus.RD1        = read_port(bus.A1);
  assign bus.RD2        = read_port(bus.A2);
  assign bus.RegWriteW  = reg_write_q;
  assign bus.WriteRegW  = write_reg_q;
  assign bus.ResultW    = result;
  assign bus.WriteCount = write_count_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, compared against an architectural register-file model.
module tb_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST;

  wb_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();
  wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural registers, one pending W write, and a commit count.
  logic [31:0] m_regs [32];
  bit          p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_val;
  logic [31:0] m_count;

  // The M-stage values currently driven by the bench.
  bit          d_we;
  bit          d_mtr;
  logic [31:0] d_rd;
  logic [31:0] d_alu;
  logic [4:0]  d_wr;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (p_we && a == p_addr) return p_val;
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    p_we    = 1'b0;
    p_addr  = 5'd0;
    p_val   = 32'd0;
    m_count = 32'd0;
  endtask

  task automatic drive(input bit we, input bit mtr, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wr);
    d_we = we; d_mtr = mtr; d_rd = rd; d_alu = alu; d_wr = wr;
    bus.RegWriteM = we;
    bus.MemtoRegM = mtr;
    bus.ReadDataM = rd;
    bus.ALUOutM   = alu;
    bus.WriteRegM = wr;
  endtask

  task automatic reads(input logic [4:0] a1, input logic [4:0] a2);
    bus.A1 = a1;
    bus.A2 = a2;
  endtask

  // Advances one clock: commits the pending W write, then moves the driven M values into W.
  task automatic step();
    @(posedge CLK);
    if (!RST) begin
      if (p_we && p_addr != 5'd0) begin
        m_regs[p_addr] = p_val;
        m_count++;
      end
      p_we   = d_we;
      p_addr = d_wr;
      p_val  = d_mtr ? d_rd : d_alu;
    end
    @(negedge CLK);
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_regwritew"}, {31'd0, bus.RegWriteW}, {31'd0, p_we});
    chk({tag, "_writeregw"}, {27'd0, bus.WriteRegW}, {27'd0, p_addr});
    chk({tag, "_resultw"}, bus.ResultW, p_val);
    chk({tag, "_count"}, bus.WriteCount, m_count);
    if (!$isunknown(bus.A1)) chk({tag, "_rd1"}, bus.RD1, exp_read(bus.A1));
    if (!$isunknown(bus.A2)) chk({tag, "_rd2"}, bus.RD2, exp_read(bus.A2));
  endtask

  initial begin
    RST = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0);
    reads(0, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_all("init");

    // ALU writeback to r5, first seen through the bypass, then from storage.
    drive(1, 0, 32'h0, 32'h0000_002A, 5'd5);
    reads(5, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_all("alu_w");
    chk("alu_bypass", bus.RD1, 32'h0000_002A);
    step();
    check_all("alu_stored");
    chk("alu_stored_rd1", bus.RD1, 32'h0000_002A);
    chk("alu_count", bus.WriteCount, 32'd1);

    // Load writeback to r31.
    drive(1, 1, 32'hDEAD_BEEF, 32'h0000_0100, 5'd31);
    reads(31, 5);
    step();
    drive(0, 0, 0, 0, 0);
    check_all("load_w");
    chk("load_resultw", bus.ResultW, 32'hDEAD_BEEF);
    step();
    check_all("load_stored");
    chk("load_stored_rd1", bus.RD1, 32'hDEAD_BEEF);

    // A write to $zero must never be visible and must not be counted.
    drive(1, 0, 0, 32'hFFFF_FFFF, 5'd0);
    reads(0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    check_all("zero_w");
    chk("zero_rd1_w", bus.RD1, 32'd0);
    step();
    check_all("zero_after");
    chk("zero_count", bus.WriteCount, 32'd2);

    // Back-to-back writes: r7=1, r7=2, r8=3.
    reads(7, 7);
    drive(1, 0, 0, 32'd1, 5'd7);
    step();
    drive(1, 0, 0, 32'd2, 5'd7);
    check_all("b2b_1");
    chk("b2b_1_rd1", bus.RD1, 32'd1);
    step();
    drive(1, 0, 0, 32'd3, 5'd8);
    check_all("b2b_2");
    chk("b2b_2_rd2", bus.RD2, 32'd2);
    step();
    drive(0, 0, 0, 0, 0);
    check_all("b2b_3");
    chk("b2b_3_rd1", bus.RD1, 32'd2);
    step();
    check_all("b2b_done");
    chk("b2b_count", bus.WriteCount, 32'd5);

    // With RegWrite off there is no bypass and no commit.
    drive(0, 0, 0, 32'h55, 5'd9);
    reads(9, 9);
    step();
    drive(0, 0, 0, 0, 0);
    check_all("nowr_w");
    chk("nowr_rd1", bus.RD1, 32'd0);
    step();
    check_all("nowr_after");

    // Unknown read addresses must not disturb the stored registers.
    reads('x, 5'd31);
    step();
    check_all("xaddr");

    // An asynchronous reset mid-cycle with a write pending in W.
    drive(1, 0, 0, 32'h77, 5'd3);
    reads(3, 3);
    step();
    drive(1, 0, 0, 32'h99, 5'd4);
    #2 RST = 1'b1;
    model_reset();
    check_all("rst_async");
    for (int a = 0; a < 32; a += 3) begin
      reads(a[4:0], 5'(31 - a));
      #1;
      chk("rst_rd1", bus.RD1, 32'd0);
      chk("rst_rd2", bus.RD2, 32'd0);
    end
    step();
    check_all("rst_held");
    RST = 1'b0;
    drive(0, 0, 0, 0, 0);
    reads(3, 4);
    check_all("rst_release");
    step();
    check_all("rst_after");
    chk("rst_lost_write", bus.RD1, 32'd0);

    // Random traffic, weighted toward a few addresses so bypass hits and overwrites occur.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr;
      logic [4:0] a1;
      logic [4:0] a2;
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, wr);
      a1 = ($urandom_range(0, 2) == 0) ? p_addr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? p_addr : 5'($urandom_range(0, 4));
      reads(a1, a2);
      check_all("rand");
      step();
    end

    // Read back the whole register file from storage.
    drive(0, 0, 0, 0, 0);
    step();
    step();
    for (int a = 0; a < 32; a++) begin
      reads(a[4:0], 5'(31 - a));
      #1;
      chk("final_rd1", bus.RD1, m_regs[a]);
      chk("final_rd2", bus.RD2, m_regs[31 - a]);
    end
    chk("final_count", bus.WriteCount, m_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
